// File: rtl/isdu_mc.sv
// isdu_mc: LC-3 instruction sequencing and decode unit for the SLC-3 datapath.
// Moore FSM driving all loads, bus gates, mux selects and SRAM strobes.
// SRAM access length is MEM_WAIT cycles, timed by the wcnt counter.
// Optional feature: define ISDU_PAUSE_EN to enable the PAUSE opcode (1101).
//
// PAUSE handshake (level based, no edge detection): PAUSE1 waits for
// ContinueIR=1, then PAUSE2 waits for ContinueIR=0 before fetching again.
module isdu_mc #(
    parameter int MEM_WAIT = 2,
    parameter int ALUK_W   = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Run,
    input  logic              ContinueIR,
    input  logic              BEN,
    input  logic [3:0]        Opcode,
    input  logic              IR_5,
    output logic              LD_MAR,
    output logic              LD_MDR,
    output logic              LD_IR,
    output logic              LD_BEN,
    output logic              LD_CC,
    output logic              LD_REG,
    output logic              LD_PC,
    output logic              LD_LED,
    output logic              GatePC,
    output logic              GateMDR,
    output logic              GateALU,
    output logic              GateMARMUX,
    output logic [1:0]        PCMUX,
    output logic              DRMUX,
    output logic              SR1MUX,
    output logic              SR2MUX,
    output logic              ADDR1MUX,
    output logic [1:0]        ADDR2MUX,
    output logic [ALUK_W-1:0] ALUK,
    output logic              Mem_CE,
    output logic              Mem_UB,
    output logic              Mem_LB,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic              Busy
);

    localparam int WCNT_W = $clog2(MEM_WAIT + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_WAIT - 1);

    localparam logic [ALUK_W-1:0] ALUK_ADD  = ALUK_W'(0);
    localparam logic [ALUK_W-1:0] ALUK_AND  = ALUK_W'(1);
    localparam logic [ALUK_W-1:0] ALUK_NOT  = ALUK_W'(2);
    localparam logic [ALUK_W-1:0] ALUK_PASS = ALUK_W'(3);

    typedef enum logic [4:0] {
        S_HALTED, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
        S_ADD, S_AND, S_NOT, S_BR, S_BR_T, S_JMP, S_JSR1, S_JSR2,
        S_LDR1, S_LDR2, S_LDR3, S_STR1, S_STR2, S_STR3
`ifdef ISDU_PAUSE_EN
        , S_PAUSE1, S_PAUSE2
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              in_mem;
    logic              mem_done;

    // Memory states share one counter; it restarts at 0 on every entry.
    assign in_mem   = (state_q == S_FETCH2) || (state_q == S_LDR2) || (state_q == S_STR3);
    assign mem_done = (wcnt_q == WCNT_LAST);
    assign wcnt_d   = (in_mem && !mem_done) ? (wcnt_q + WCNT_W'(1)) : '0;

    // State and wait-counter registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= S_HALTED;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

`ifdef ISDU_PAUSE_EN
    logic led_q, led_d;

    // LD_LED pulses only in the first PAUSE1 cycle, not while stalled there.
    assign led_d  = (state_q != S_PAUSE1) && (state_d == S_PAUSE1);
    assign LD_LED = led_q;
    assign Busy   = !((state_q == S_HALTED) || (state_q == S_PAUSE1) || (state_q == S_PAUSE2));

    // Registered LED entry pulse.
    always_ff @(posedge Clk) begin
        if (!Reset_n) led_q <= 1'b0;
        else          led_q <= led_d;
    end
`else
    logic unused_continue;
    assign unused_continue = ContinueIR;
    assign LD_LED = 1'b0;
    assign Busy   = (state_q != S_HALTED);
`endif

    assign Mem_CE = 1'b0;
    assign Mem_UB = 1'b0;
    assign Mem_LB = 1'b0;

    // Next-state logic, including opcode dispatch and memory wait exits.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HALTED: if (Run) state_d = S_FETCH1;
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: if (mem_done) state_d = S_FETCH3;
            S_FETCH3: state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    4'b0001: state_d = S_ADD;
                    4'b0101: state_d = S_AND;
                    4'b1001: state_d = S_NOT;
                    4'b0000: state_d = S_BR;
                    4'b1100: state_d = S_JMP;
                    4'b0100: state_d = S_JSR1;
                    4'b0110: state_d = S_LDR1;
                    4'b0111: state_d = S_STR1;
`ifdef ISDU_PAUSE_EN
                    4'b1101: state_d = S_PAUSE1;
`endif
                    default: state_d = S_FETCH1;
                endcase
            end
            S_BR:    state_d = BEN ? S_BR_T : S_FETCH1;
            S_JSR1:  state_d = S_JSR2;
            S_LDR1:  state_d = S_LDR2;
            S_LDR2:  if (mem_done) state_d = S_LDR3;
            S_STR1:  state_d = S_STR2;
            S_STR2:  state_d = S_STR3;
            S_STR3:  if (mem_done) state_d = S_FETCH1;
`ifdef ISDU_PAUSE_EN
            S_PAUSE1: if (ContinueIR) state_d = S_PAUSE2;
            S_PAUSE2: if (!ContinueIR) state_d = S_FETCH1;
`endif
            S_ADD, S_AND, S_NOT, S_BR_T, S_JMP, S_JSR2, S_LDR3: state_d = S_FETCH1;
            default: state_d = S_HALTED;
        endcase
    end

    // Moore control outputs; SR2MUX follows IR_5 only in ADD/AND.
    always_comb begin
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = 2'b00;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = 2'b00;
        ALUK       = ALUK_ADD;
        Mem_OE     = 1'b1;
        Mem_WE     = 1'b1;
        case (state_q)
            S_FETCH1: begin GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; end
            S_FETCH2, S_LDR2: begin Mem_OE = 1'b0; LD_MDR = mem_done; end
            S_FETCH3: begin GateMDR = 1'b1; LD_IR = 1'b1; end
            S_DECODE: LD_BEN = 1'b1;
            S_ADD: begin GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; ALUK = ALUK_ADD; SR2MUX = IR_5; end
            S_AND: begin GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; ALUK = ALUK_AND; SR2MUX = IR_5; end
            S_NOT: begin GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; ALUK = ALUK_NOT; end
            S_BR_T: begin ADDR2MUX = 2'b10; PCMUX = 2'b10; LD_PC = 1'b1; end
            S_JMP: begin ADDR1MUX = 1'b1; PCMUX = 2'b10; LD_PC = 1'b1; end
            S_JSR1: begin DRMUX = 1'b1; GatePC = 1'b1; LD_REG = 1'b1; end
            S_JSR2: begin ADDR2MUX = 2'b11; PCMUX = 2'b10; LD_PC = 1'b1; end
            S_LDR1, S_STR1: begin ADDR1MUX = 1'b1; ADDR2MUX = 2'b01; GateMARMUX = 1'b1; LD_MAR = 1'b1; end
            S_LDR3: begin GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
            S_STR2: begin SR1MUX = 1'b1; ALUK = ALUK_PASS; GateALU = 1'b1; LD_MDR = 1'b1; end
            S_STR3: Mem_WE = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: doc/isdu_mc.md
# isdu_mc

Parameterised LC-3 instruction sequencing and decode unit for the SLC-3 datapath. It drives every load enable, bus gate, mux select and SRAM strobe from a Moore state machine. Memory access time is set by a wait-state parameter and enforced by an internal counter, so the block fits slower SRAM without adding states. It supports ADD, AND, NOT, BR, JMP, JSR, LDR, STR and an optional PAUSE, and sits between the IR/BEN logic and the datapath muxes.

## Interface
- MEM_WAIT, 2, cycles Mem_OE/Mem_WE stay low per access; legal 1..8
- ALUK_W, 2, ALUK width; encodings 0 add, 1 and, 2 not, 3 pass-A
- Clk  in  1  clock; all state changes on the rising edge
- Reset_n  in  1  reset; one clock, synchronous, active-low
- Run  in  1  leave HALTED
- ContinueIR  in  1  PAUSE release handshake
- BEN  in  1  registered branch-enable from the datapath
- Opcode  in  4  IR[15:12]
- IR_5  in  1  IR[5], immediate select
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register loads, active-high
- GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers; at most one high per cycle
- PCMUX  out  2  00 PC+1, 01 bus, 10 address adder
- DRMUX  out  1  0 IR[11:9], 1 R7
- SR1MUX  out  1  0 IR[8:6], 1 IR[11:9]
- SR2MUX  out  1  0 register, 1 sext(imm5)
- ADDR1MUX  out  1  0 PC, 1 SR1
- ADDR2MUX  out  2  00 zero, 01 off6, 10 off9, 11 off11
- ALUK  out  ALUK_W  ALU operation
- Mem_CE, Mem_UB, Mem_LB  out  1 each  tied 0
- Mem_OE, Mem_WE  out  1 each  active-low strobes
- Busy  out  1  high in any state except HALTED and PAUSE1/PAUSE2

## Operation
- Outputs are combinational from the state only (Moore), except SR2MUX = IR_5 in ADD/AND.
- Default outputs in every state: all LD_*/Gate* 0, PCMUX 00, muxes 0, ALUK add, Mem_OE=Mem_WE=1.
- HALTED: go to FETCH1 when Run=1.
- FETCH1: GatePC, LD_MAR, LD_PC (PC+1).
- FETCH2: Mem_OE=0. The counter wcnt counts 0..MEM_WAIT-1. LD_MDR is high only when wcnt=MEM_WAIT-1, and that cycle exits to FETCH3.
- FETCH3: GateMDR, LD_IR. Next state DECODE.
- DECODE: LD_BEN. Dispatch on Opcode:
  - 0001 ADD, 0101 AND, 1001 NOT, 0000 BR, 1100 JMP, 0100 JSR, 0110 LDR1, 0111 STR1, 1101 PAUSE1.
  - Any other opcode returns to FETCH1.
- ADD/AND/NOT: GateALU, LD_REG, LD_CC, ALUK 0/1/2. Then FETCH1.
- BR: if BEN=1 go to BR_T, else FETCH1. BR_T: ADDR1MUX 0, ADDR2MUX 10, PCMUX 10, LD_PC. Then FETCH1.
- JMP: ADDR1MUX 1, ADDR2MUX 00, PCMUX 10, LD_PC. Then FETCH1.
- JSR1: DRMUX 1, GatePC, LD_REG. JSR2: ADDR2MUX 11, PCMUX 10, LD_PC. Then FETCH1.
- LDR1: ADDR1MUX 1, ADDR2MUX 01, GateMARMUX, LD_MAR.
- LDR2: read with the same counter rule as FETCH2.
- LDR3: GateMDR, LD_REG, LD_CC.
- STR1: same outputs as LDR1.
- STR2: SR1MUX 1, ALUK 3, GateALU, LD_MDR.
- STR3: Mem_WE=0 for MEM_WAIT cycles, Mem_OE=1, counter as above. Then FETCH1.
- PAUSE1: LD_LED for one cycle on entry; wait for ContinueIR=1, then go to PAUSE2. PAUSE2: wait for ContinueIR=0, then go to FETCH1.
- wcnt is $clog2(MEM_WAIT+1) bits. It clears on entry to any memory state and never wraps past MEM_WAIT-1. With MEM_WAIT=1, every memory state lasts exactly one cycle.

## Timing
- Reset_n=0 at an edge forces HALTED, wcnt=0. All outputs take their defaults in the next cycle, including an aborted STR3 (Mem_WE returns to 1).
- Instruction length in cycles, fetch + execute:
  - ADD/AND/NOT/JMP/BR-not-taken: 3+MEM_WAIT+1
  - BR taken, JSR: 3+MEM_WAIT+2
  - LDR: 3+MEM_WAIT+2+MEM_WAIT
  - STR: 3+MEM_WAIT+2+MEM_WAIT
- Run is sampled only in HALTED. Dropping Run mid-program has no effect.
- ContinueIR held high through PAUSE1 passes to PAUSE2 in one cycle, then stalls until it falls. This is a full level handshake with no edge detection.
- Mem_OE and Mem_WE are never both low in any cycle.

## Configuration
- ISDU_PAUSE_EN defined: opcode 1101 enters PAUSE1/PAUSE2 and LD_LED is driven as above.
- ISDU_PAUSE_EN undefined: PAUSE states and the ContinueIR logic are removed. Opcode 1101 decodes as illegal and returns to FETCH1, and LD_LED is tied 0.

## Test plan
- Reset then Run=1, MEM_WAIT=2, Opcode 0001 IR_5=1 -> FETCH2 Mem_OE low for 2 cycles with LD_MDR in the 2nd; ADD asserts GateALU/LD_REG/LD_CC with SR2MUX=1; total 6 cycles, back in FETCH1.
- Opcode 0000 with BEN=0 then BEN=1 -> not taken: no LD_PC after decode; taken: BR_T asserts PCMUX=10, ADDR2MUX=10, LD_PC.
- MEM_WAIT=3, Opcode 0111 -> STR3 holds Mem_WE=0 for exactly 3 cycles with Mem_OE=1; SR1MUX=1, ALUK=3 in STR2.
- Opcode 0110, MEM_WAIT=1 -> LDR2 is one cycle with Mem_OE=0 and LD_MDR=1; LDR3 asserts GateMDR, LD_REG, LD_CC.
- Opcode 1101 with ISDU_PAUSE_EN -> LD_LED pulses once, Busy=0; ContinueIR 1 then 0 resumes at FETCH1. Without the macro -> direct return to FETCH1.
- Reset_n=0 during STR3 cycle 1 -> next cycle HALTED, Mem_WE=1, all loads 0, Busy=0.
